// File: rtl/div_issue_ctrl_if.sv
// Bundle between the EX-stage pipeline/divider environment and div_issue_ctrl.
// The controller connects through the slave modport; the environment uses master.
interface div_issue_ctrl_if;
    logic        ex_valid;
    logic        ex_is_div;
    logic [1:0]  ex_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic        ex_advance;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        div_start;
    logic        div_is_unsigned;
    logic        div_is_rem;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_result;
    logic        div_busy;
    logic        div_done;

    modport slave (
        input  ex_valid, ex_is_div, ex_funct3, ex_rs1, ex_rs2, ex_advance, flush,
        input  div_result, div_busy, div_done,
        output stall, result, result_valid, div_start,
        output div_is_unsigned, div_is_rem, div_dividend, div_divisor
    );

    modport master (
        output ex_valid, ex_is_div, ex_funct3, ex_rs1, ex_rs2, ex_advance, flush,
        output div_result, div_busy, div_done,
        input  stall, result, result_valid, div_start,
        input  div_is_unsigned, div_is_rem, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage controller for the iterative divider: issues, stalls EX until done,
// holds the result until EX advances, drains after flush, one-entry result cache.
module div_issue_ctrl #(
    parameter bit ENABLE_CACHE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    div_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        cache_valid_q, cache_valid_d;
    logic [65:0] cache_tag_q, cache_tag_d;
    logic [31:0] cache_data_q, cache_data_d;
    logic [65:0] op_tag_q, op_tag_d;
    logic [31:0] latch_q, latch_d;

    logic        req_s;
    logic        hit_s;
    logic [65:0] tag_s;
    logic        start_s;
    logic        rv_s;
    logic [31:0] res_s;

    assign req_s = bus.ex_valid & bus.ex_is_div & ~bus.flush;
    assign tag_s = {bus.ex_rs1, bus.ex_rs2, bus.ex_funct3};
    assign hit_s = ENABLE_CACHE & cache_valid_q & (cache_tag_q == tag_s);

    // Next-state, cache update and per-cycle result/start decode
    always_comb begin
        state_d       = state_q;
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        op_tag_d      = op_tag_q;
        latch_d       = latch_q;
        start_s       = 1'b0;
        rv_s          = 1'b0;
        res_s         = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (req_s && hit_s) begin
                    rv_s  = 1'b1;
                    res_s = cache_data_q;
                end else if (req_s && !bus.div_busy) begin
                    start_s  = 1'b1;
                    op_tag_d = tag_s;
                    state_d  = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // A flush coinciding with done kills the result; the divider is already free
                if (bus.flush) begin
                    state_d = bus.div_done ? S_IDLE : S_DRAIN;
                end else if (bus.div_done) begin
                    rv_s          = 1'b1;
                    res_s         = bus.div_result;
                    cache_valid_d = 1'b1;
                    cache_tag_d   = op_tag_q;
                    cache_data_d  = bus.div_result;
                    if (bus.ex_advance) begin
                        state_d = S_IDLE;
                    end else begin
                        latch_d = bus.div_result;
                        state_d = S_HOLD;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                rv_s  = 1'b1;
                res_s = latch_q;
                if (bus.ex_advance || bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (bus.div_done) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, cache and hold-latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= 66'd0;
            cache_data_q  <= 32'd0;
            op_tag_q      <= 66'd0;
            latch_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
            op_tag_q      <= op_tag_d;
            latch_q       <= latch_d;
        end
    end

    assign bus.stall           = ~rst & bus.ex_valid & bus.ex_is_div & ~rv_s & ~bus.flush;
    assign bus.result_valid    = ~rst & rv_s;
    assign bus.result          = rst ? 32'd0 : res_s;
    assign bus.div_start       = ~rst & start_s;
    assign bus.div_is_unsigned = ~rst & bus.ex_funct3[0];
    assign bus.div_is_rem      = ~rst & bus.ex_funct3[1];
    assign bus.div_dividend    = rst ? 32'd0 : bus.ex_rs1;
    assign bus.div_divisor     = rst ? 32'd0 : bus.ex_rs2;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural 33-cycle divider responder.
module tb_div_issue_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_issue_ctrl_if bus();

    div_issue_ctrl #(.ENABLE_CACHE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f3);
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
        if (f3[0]) return f3[1] ? (a % b) : (a / b);
        return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    endfunction

    // Divider responder: special cases finish next cycle, others 33 cycles after start
    logic [5:0]  cnt;
    logic [31:0] pend;
    always @(posedge clk) begin
        if (rst) begin
            bus.div_busy   <= 1'b0;
            bus.div_done   <= 1'b0;
            bus.div_result <= 32'd0;
            cnt            <= 6'd0;
            pend           <= 32'd0;
        end else begin
            bus.div_done <= 1'b0;
            if (bus.div_start) begin
                if (bus.div_divisor == 32'd0 ||
                    (!bus.div_is_unsigned && bus.div_dividend == 32'h8000_0000 && bus.div_divisor == 32'hFFFF_FFFF)) begin
                    bus.div_done   <= 1'b1;
                    bus.div_result <= ref_div(bus.div_dividend, bus.div_divisor, {bus.div_is_rem, bus.div_is_unsigned});
                end else begin
                    bus.div_busy <= 1'b1;
                    cnt          <= 6'd32;
                    pend         <= ref_div(bus.div_dividend, bus.div_divisor, {bus.div_is_rem, bus.div_is_unsigned});
                end
            end else if (bus.div_busy) begin
                if (cnt == 6'd1) begin
                    bus.div_busy   <= 1'b0;
                    bus.div_done   <= 1'b1;
                    bus.div_result <= pend;
                end else begin
                    cnt <= cnt - 6'd1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f3, input logic adv);
        bus.ex_valid   = 1'b1;
        bus.ex_is_div  = 1'b1;
        bus.ex_rs1     = a;
        bus.ex_rs2     = b;
        bus.ex_funct3  = f3;
        bus.ex_advance = adv;
        bus.flush      = 1'b0;
    endtask

    // Runs the presented op until result_valid (bounded), then two idle cycles
    task automatic measure(output int n_stall, output int n_start, output int n_rv,
                           output int n_busy, output int start_at, output logic [31:0] res);
        bit seen = 1'b0;
        n_stall = 0; n_start = 0; n_rv = 0; n_busy = 0; start_at = -1; res = 32'd0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.stall) n_stall++;
            if (bus.div_start) begin
                n_start++;
                if (start_at < 0) start_at = i;
            end
            if (bus.div_busy) n_busy++;
            if (bus.result_valid) begin
                n_rv++;
                res  = bus.result;
                seen = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.ex_valid   = 1'b0;
        bus.ex_advance = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.stall) n_stall++;
            if (bus.div_start) n_start++;
            if (bus.result_valid) n_rv++;
            @(posedge clk); #1;
        end
    endtask

    int          ns, nst, nrv, nb, sat;
    logic [31:0] r;

    initial begin
        rst = 1'b1;
        present(32'd100, 32'd7, 2'b01, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_start", 32'(bus.div_start), 32'd0);
        chk("rst_rv", 32'(bus.result_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_dividend", bus.div_dividend, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.ex_valid = 1'b0;
        @(negedge clk);
        chk("idle_rv", 32'(bus.result_valid), 32'd0);
        chk("idle_start", 32'(bus.div_start), 32'd0);
        @(posedge clk); #1;

        // DIVU 100/7, advance held
        present(32'd100, 32'd7, 2'b01, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("divu_stall", 32'(ns), 32'd33);
        chk("divu_start", 32'(nst), 32'd1);
        chk("divu_rv", 32'(nrv), 32'd1);
        chk("divu_res", r, 32'd14);

        // Same op again: cache hit
        present(32'd100, 32'd7, 2'b01, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("hit_stall", 32'(ns), 32'd0);
        chk("hit_start", 32'(nst), 32'd0);
        chk("hit_res", r, 32'd14);

        // REMU 100/7 misses
        present(32'd100, 32'd7, 2'b11, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("remu_start", 32'(nst), 32'd1);
        chk("remu_stall", 32'(ns), 32'd33);
        chk("remu_res", r, 32'd2);

        // REM -7 % 2
        present(32'hFFFF_FFF9, 32'd2, 2'b10, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("rem_neg_res", r, 32'hFFFF_FFFF);

        // DIV overflow
        present(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("ovf_res", r, 32'h8000_0000);
        chk("ovf_stall", 32'(ns), 32'd1);
        chk("ovf_busy", 32'(nb), 32'd0);

        // DIV 5/0 and REMU 5/0
        present(32'd5, 32'd0, 2'b00, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("div0_res", r, 32'hFFFF_FFFF);
        chk("div0_stall", 32'(ns), 32'd1);
        chk("div0_busy", 32'(nb), 32'd0);
        present(32'd5, 32'd0, 2'b11, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("remu0_res", r, 32'd5);
        chk("remu0_stall", 32'(ns), 32'd1);
        chk("remu0_busy", 32'(nb), 32'd0);

        // Reset clears the cache; outputs low during reset
        rst = 1'b1;
        present(32'd100, 32'd7, 2'b01, 1'b1);
        @(negedge clk);
        chk("rst2_start", 32'(bus.div_start), 32'd0);
        chk("rst2_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // DIVU 100/7 after reset misses; flushed at T+10
        @(negedge clk);
        chk("postrst_start", 32'(bus.div_start), 32'd1);
        chk("issue_dividend", bus.div_dividend, 32'd100);
        chk("issue_divisor", bus.div_divisor, 32'd7);
        chk("issue_unsigned", 32'(bus.div_is_unsigned), 32'd1);
        chk("issue_rem", 32'(bus.div_is_rem), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_rv", 32'(bus.result_valid), 32'd0);
        chk("flush_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        present(32'd9, 32'd3, 2'b01, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("drain_issue_at", 32'(sat), 32'd23);
        chk("drain_stall", 32'(ns), 32'd56);
        chk("drain_rv", 32'(nrv), 32'd1);
        chk("drain_res", r, 32'd3);

        // Completion without advance: hold for 5 cycles
        present(32'd100, 32'd7, 2'b01, 1'b0);
        ns = 0; nrv = 0;
        for (int i = 0; i < 60 && nrv == 0; i++) begin
            @(negedge clk);
            if (bus.stall) ns++;
            if (bus.result_valid) nrv++;
            r = bus.result;
            @(posedge clk); #1;
        end
        chk("hold_wait_stall", 32'(ns), 32'd33);
        chk("hold_first_rv", 32'(nrv), 32'd1);
        chk("hold_first_res", r, 32'd14);
        bus.ex_rs1 = 32'd1234;
        bus.ex_rs2 = 32'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rv", 32'(bus.result_valid), 32'd1);
            chk("hold_res", bus.result, 32'd14);
            chk("hold_stall", 32'(bus.stall), 32'd0);
            @(posedge clk); #1;
        end
        bus.ex_advance = 1'b1;
        @(negedge clk);
        chk("hold_adv_rv", 32'(bus.result_valid), 32'd1);
        @(posedge clk); #1;
        bus.ex_valid   = 1'b0;
        bus.ex_advance = 1'b0;
        @(negedge clk);
        chk("after_hold_rv", 32'(bus.result_valid), 32'd0);
        @(posedge clk); #1;

        // Held completion filled the cache
        present(32'd100, 32'd7, 2'b01, 1'b1);
        measure(ns, nst, nrv, nb, sat, r);
        chk("hit2_start", 32'(nst), 32'd0);
        chk("hit2_stall", 32'(ns), 32'd0);
        chk("hit2_res", r, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
